counter_down_timer_ctrl: RTL and testbench
==========================================

Name: counter_down_timer_ctrl

Overview:
Synchronous controller that sequences a WIDTH-bit down counter as a programmable countdown timer. It supports load, run, pause/resume, terminal-count detection, one-shot or auto-reload mode, and a Done/Ack completion handshake. It is the sequencing layer placed in front of down-counter datapaths, and it replaces ripple-clocked counting with a single-clock design.

Parameters:
WIDTH, 4, counter and load-value width in bits
PRESCALE, 1, Clk cycles per count decrement (>=1); 1 means decrement every cycle

Ports:
Clk  input  1  single system clock, all state updates on rising edge
Clr  input  1  synchronous active-high reset
LoadVal  input  WIDTH  start/reload value, sampled on Start (from IDLE) and at each auto-reload
Start  input  1  start from IDLE; resume from PAUSE
Stop  input  1  pause from RUN; abort from PAUSE
AutoReload  input  1  sampled at terminal tick; 1 = reload and continue, 0 = one-shot
Ack  input  1  acknowledges Done
count  output  WIDTH  current count value
Busy  output  1  high in RUN or PAUSE
Paused  output  1  high in PAUSE
Done  output  1  level, high in DONE until acknowledged
Tc  output  1  one-cycle terminal-count pulse

Behaviour:
- Clock and reset: one clock, Clk; reset is synchronous and active-high on Clr. Clr sampled high at a Clk edge sets state=IDLE, count=0, prescaler=0, Busy=0, Paused=0, Done=0, Tc=0. Clr overrides all other inputs in every state, including mid-count.
- All outputs are registered. Tc defaults to 0 every cycle unless set as stated below.
- Internal tick: prescaler counts 0..PRESCALE-1 in RUN only. tick = (prescaler==PRESCALE-1); prescaler wraps to 0 on tick. Prescaler is held in PAUSE and cleared on entry to RUN from IDLE.
- IDLE:
  - Start=1, Stop=0, LoadVal!=0: count<=LoadVal, go RUN. Busy=1 from the next cycle.
  - Start=1, LoadVal==0: count<=0, Tc<=1, go DONE.
  - Start and Stop both high: Stop wins, remain IDLE.
- RUN:
  - Stop=1: go PAUSE with count and prescaler held. Stop has priority over a coincident tick.
  - tick with count>1: count<=count-1.
  - tick with count==1 and AutoReload=1: Tc<=1, count<=LoadVal, stay RUN. If that LoadVal==0: count<=0, go DONE.
  - tick with count==1 and AutoReload=0: Tc<=1, count<=0, go DONE.
  - Period in RUN = LoadVal*PRESCALE cycles from RUN entry to the Tc pulse.
- PAUSE:
  - Start=1: return to RUN with no reload; count and prescaler resume.
  - Stop=1: abort to IDLE, count<=0, no Tc.
  - Start and Stop both high: Stop wins.
- DONE:
  - Done=1, Busy=0.
  - Ack=1: go IDLE; Done clears on the same edge.
  - Start is ignored in DONE, including when coincident with Ack. A new Start must be presented in IDLE.
- count never wraps: decrement below 0 is impossible by construction. Subtraction is WIDTH-bit modulo, but count==0 is never decremented.

Optional Feature:
Macro COUNTER_DOWN_TIMER_CTRL_RELOAD_CNT_EN.
- Defined: adds output ReloadCnt (WIDTH bits).
  - Increments on every auto-reload Tc that stays in RUN.
  - Saturates at all-ones.
  - Cleared by Clr and on Start from IDLE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: Clr=1 for 2 cycles mid-RUN with count=7 -> after the edge, count=0, Busy=0, Done=0, Tc=0, state IDLE.
- One-shot: PRESCALE=1, LoadVal=3, Start pulse -> count 3,2,1,0 on successive cycles; Tc=1 exactly with count=0; Done=1 held until Ack; Done=0 after the Ack edge.
- Auto-reload: LoadVal=2, AutoReload=1, PRESCALE=2 -> Tc pulses every 4 cycles; count sequence 2,2,1,1,2,...; Done never asserts; with the macro, ReloadCnt increments per Tc and saturates at 15.
- Pause/resume: LoadVal=5, Stop at count=3 -> count holds 3 for 4 idle cycles with Paused=1; Start -> continues 2,1,0 with no reload; total Tc latency is extended by exactly the pause length.
- Abort and priorities: Stop in PAUSE -> IDLE, count=0, Tc never pulses; Start+Stop together in IDLE -> stays IDLE; Start+Ack in DONE -> IDLE, no new run.
- Zero load: Start with LoadVal=0 -> next cycle Tc=1, Done=1, count=0, Busy never asserts.

Source files
------------

// File: rtl/counter_down_timer_ctrl.sv
// Programmable countdown timer sequencer: load, run, pause/resume, one-shot or auto-reload, Done/Ack handshake.
// Optional ReloadCnt output enabled by defining COUNTER_DOWN_TIMER_CTRL_RELOAD_CNT_EN.
module counter_down_timer_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             Start,
    input  logic             Stop,
    input  logic             AutoReload,
    input  logic             Ack,
    output logic [WIDTH-1:0] count,
`ifdef COUNTER_DOWN_TIMER_CTRL_RELOAD_CNT_EN
    output logic [WIDTH-1:0] ReloadCnt,
`endif
    output logic             Busy,
    output logic             Paused,
    output logic             Done,
    output logic             Tc
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [PW-1:0]    presc_reg, presc_next;
    logic             tc_reg, tc_next;
    logic             busy_reg, paused_reg, done_reg;
    logic             tick;
    logic             at_one;
    logic             load_zero;

    assign tick      = (presc_reg == PW'(PRESCALE - 1));
    assign at_one    = (count_reg == WIDTH'(1));
    assign load_zero = (LoadVal == '0);

    // State and datapath registers; status flags are registered from the next state.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_reg  <= S_IDLE;
            count_reg  <= '0;
            presc_reg  <= '0;
            tc_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            paused_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            presc_reg  <= presc_next;
            tc_reg     <= tc_next;
            busy_reg   <= (state_next == S_RUN) || (state_next == S_PAUSE);
            paused_reg <= (state_next == S_PAUSE);
            done_reg   <= (state_next == S_DONE);
        end
    end

    // Next-state logic; Stop always dominates a coincident Start or tick.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (Start && !Stop)
                    state_next = load_zero ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (Stop)
                    state_next = S_PAUSE;
                else if (tick && at_one && (!AutoReload || load_zero))
                    state_next = S_DONE;
            end
            S_PAUSE: begin
                if (Stop)
                    state_next = S_IDLE;
                else if (Start)
                    state_next = S_RUN;
            end
            S_DONE: begin
                if (Ack)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and Tc; count==0 is never decremented so the counter cannot wrap.
    always_comb begin
        count_next = count_reg;
        presc_next = presc_reg;
        tc_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (Start && !Stop) begin
                    count_next = LoadVal;
                    presc_next = '0;
                    tc_next    = load_zero;
                end
            end
            S_RUN: begin
                if (!Stop) begin
                    if (tick) begin
                        presc_next = '0;
                        if (count_reg > WIDTH'(1)) begin
                            count_next = count_reg - WIDTH'(1);
                        end else if (at_one) begin
                            tc_next    = 1'b1;
                            count_next = AutoReload ? LoadVal : '0;
                        end
                    end else begin
                        presc_next = presc_reg + PW'(1);
                    end
                end
            end
            S_PAUSE: begin
                if (Stop)
                    count_next = '0;
            end
            default: ;
        endcase
    end

`ifdef COUNTER_DOWN_TIMER_CTRL_RELOAD_CNT_EN
    logic [WIDTH-1:0] reload_cnt_reg;
    logic             start_idle;
    logic             reload_stay;

    assign start_idle  = (state_reg == S_IDLE) && Start && !Stop;
    assign reload_stay = (state_reg == S_RUN) && !Stop && tick && at_one
                         && AutoReload && !load_zero;

    always_ff @(posedge Clk) begin
        if (Clr || start_idle)
            reload_cnt_reg <= '0;
        else if (reload_stay && (reload_cnt_reg != '1))
            reload_cnt_reg <= reload_cnt_reg + WIDTH'(1);
    end

    assign ReloadCnt = reload_cnt_reg;
`endif

    assign count  = count_reg;
    assign Busy   = busy_reg;
    assign Paused = paused_reg;
    assign Done   = done_reg;
    assign Tc     = tc_reg;

endmodule

// File: tb/tb_counter_down_timer_ctrl.sv
// Directed bench for counter_down_timer_ctrl: vector table on a PRESCALE=1 instance,
// plus hand-written auto-reload sequences (PRESCALE=2 instance, optional ReloadCnt).
module tb_counter_down_timer_ctrl;

    logic       Clk = 1'b0;
    logic       Clr, Start, Stop, AutoReload, Ack;
    logic [3:0] LoadVal;
    logic [3:0] count1, count2;
    logic       busy1, paused1, done1, tc1;
    logic       busy2, paused2, done2, tc2;
`ifdef COUNTER_DOWN_TIMER_CTRL_RELOAD_CNT_EN
    logic [3:0] rc1, rc2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    counter_down_timer_ctrl #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .Clk(Clk), .Clr(Clr), .LoadVal(LoadVal), .Start(Start), .Stop(Stop),
        .AutoReload(AutoReload), .Ack(Ack), .count(count1),
`ifdef COUNTER_DOWN_TIMER_CTRL_RELOAD_CNT_EN
        .ReloadCnt(rc1),
`endif
        .Busy(busy1), .Paused(paused1), .Done(done1), .Tc(tc1)
    );

    counter_down_timer_ctrl #(.WIDTH(4), .PRESCALE(2)) dut2 (
        .Clk(Clk), .Clr(Clr), .LoadVal(LoadVal), .Start(Start), .Stop(Stop),
        .AutoReload(AutoReload), .Ack(Ack), .count(count2),
`ifdef COUNTER_DOWN_TIMER_CTRL_RELOAD_CNT_EN
        .ReloadCnt(rc2),
`endif
        .Busy(busy2), .Paused(paused2), .Done(done2), .Tc(tc2)
    );

    typedef struct {
        logic       clr, start, stop, ar, ack;
        logic [3:0] lv;
        logic [3:0] c;
        logic       b, p, d, t;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic clr, input logic start, input logic stop, input logic ar,
                     input logic ack, input logic [3:0] lv, input logic [3:0] c,
                     input logic b, input logic p, input logic d, input logic t);
        vec_t e;
        e.clr = clr; e.start = start; e.stop = stop; e.ar = ar; e.ack = ack; e.lv = lv;
        e.c = c; e.b = b; e.p = p; e.d = d; e.t = t;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic start, input logic stop, input logic ar,
                         input logic ack, input logic [3:0] lv);
        Clr = clr; Start = start; Stop = stop; AutoReload = ar; Ack = ack; LoadVal = lv;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);

        //  clr st sp ar ak lv   cnt busy paus done tc
        v(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 0, 3,   3, 1, 0, 0, 0);  // one-shot 3,2,1,0
        v(0, 0, 0, 0, 0, 3,   2, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 3,   1, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 3,   0, 0, 0, 1, 1);
        v(0, 0, 0, 0, 0, 3,   0, 0, 0, 1, 0);
        v(0, 1, 0, 0, 0, 3,   0, 0, 0, 1, 0);  // Start ignored in DONE
        v(0, 0, 0, 0, 1, 3,   0, 0, 0, 0, 0);
        v(0, 1, 1, 0, 0, 5,   0, 0, 0, 0, 0);  // Start+Stop in IDLE
        v(0, 1, 0, 0, 0, 5,   5, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 5,   4, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 5,   3, 1, 0, 0, 0);
        v(0, 0, 1, 0, 0, 5,   3, 1, 1, 0, 0);  // Stop beats tick
        v(0, 0, 0, 0, 0, 5,   3, 1, 1, 0, 0);
        v(0, 0, 0, 0, 0, 5,   3, 1, 1, 0, 0);
        v(0, 0, 0, 0, 0, 5,   3, 1, 1, 0, 0);
        v(0, 1, 0, 0, 0, 5,   3, 1, 0, 0, 0);  // resume, no reload
        v(0, 0, 0, 0, 0, 5,   2, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 5,   1, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 5,   0, 0, 0, 1, 1);
        v(0, 0, 0, 0, 1, 5,   0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 0, 2,   2, 1, 0, 0, 0);
        v(0, 0, 1, 0, 0, 2,   2, 1, 1, 0, 0);
        v(0, 0, 1, 0, 0, 2,   0, 0, 0, 0, 0);  // abort from PAUSE
        v(0, 0, 0, 0, 0, 2,   0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 1);  // zero load
        v(0, 1, 0, 0, 1, 3,   0, 0, 0, 0, 0);  // Start+Ack in DONE
        v(0, 0, 0, 0, 0, 3,   0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 0, 7,   7, 1, 0, 0, 0);
        v(1, 0, 0, 0, 0, 7,   0, 0, 0, 0, 0);  // reset mid-run
        v(1, 0, 0, 0, 0, 7,   0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 7,   0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 0, 4,   4, 1, 0, 0, 0);
        v(0, 0, 1, 0, 0, 4,   4, 1, 1, 0, 0);
        v(0, 1, 1, 0, 0, 4,   0, 0, 0, 0, 0);  // Start+Stop in PAUSE
        v(0, 1, 0, 1, 0, 2,   2, 1, 0, 0, 0);  // auto-reload, PRESCALE=1
        v(0, 0, 0, 1, 0, 2,   1, 1, 0, 0, 0);
        v(0, 0, 0, 1, 0, 2,   2, 1, 0, 0, 1);
        v(0, 0, 0, 1, 0, 2,   1, 1, 0, 0, 0);
        v(0, 0, 0, 1, 0, 2,   2, 1, 0, 0, 1);
        v(0, 0, 0, 0, 0, 2,   1, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 2,   0, 0, 0, 1, 1);
        v(0, 0, 0, 0, 1, 2,   0, 0, 0, 0, 0);
        v(0, 1, 0, 1, 0, 2,   2, 1, 0, 0, 0);
        v(0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 0);
        v(0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 1);  // reload with LoadVal=0
        v(0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].start, vecs[i].stop, vecs[i].ar, vecs[i].ack, vecs[i].lv);
            @(posedge Clk); #1;
            chk("count",  i, count1,        vecs[i].c);
            chk("busy",   i, {3'b0, busy1},   {3'b0, vecs[i].b});
            chk("paused", i, {3'b0, paused1}, {3'b0, vecs[i].p});
            chk("done",   i, {3'b0, done1},   {3'b0, vecs[i].d});
            chk("tc",     i, {3'b0, tc1},     {3'b0, vecs[i].t});
            $display("vec %0d: count=%0d busy=%0b paused=%0b done=%0b tc=%0b", i, count1, busy1, paused1, done1, tc1);
        end

        // PRESCALE=2 auto-reload: count 2,2,1,1 repeating, Tc every 4th cycle
        drive(1, 0, 0, 0, 0, 0);
        @(posedge Clk); #1;
        drive(0, 1, 0, 1, 0, 2);
        @(posedge Clk); #1;
        chk("p2_start_count", 0, count2, 4'd2);
        drive(0, 0, 0, 1, 0, 2);
        for (int k = 1; k <= 12; k++) begin
            logic [3:0] ec;
            ec = ((k % 4) == 1 || (k % 4) == 0) ? 4'd2 : 4'd1;
            @(posedge Clk); #1;
            chk("p2_count", k, count2, ec);
            chk("p2_tc",    k, {3'b0, tc2},   {3'b0, ((k % 4) == 0)});
            chk("p2_done",  k, {3'b0, done2}, 4'd0);
            chk("p2_busy",  k, {3'b0, busy2}, 4'd1);
            $display("p2 cycle %0d: count=%0d tc=%0b", k, count2, tc2);
        end

`ifdef COUNTER_DOWN_TIMER_CTRL_RELOAD_CNT_EN
        // LoadVal=1 on PRESCALE=1 reloads every cycle; ReloadCnt saturates at 15
        drive(1, 0, 0, 0, 0, 0);
        @(posedge Clk); #1;
        chk("rc_reset", 0, rc1, 4'd0);
        drive(0, 1, 0, 1, 0, 1);
        @(posedge Clk); #1;
        chk("rc_start", 0, rc1, 4'd0);
        drive(0, 0, 0, 1, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clk); #1;
            chk("rc_count", k, rc1, (k > 15) ? 4'd15 : 4'(k));
            $display("rc cycle %0d: ReloadCnt=%0d tc=%0b", k, rc1, tc1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
